// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: produces the SCL drive with a programmable half period,
// detects clock stretching by the target, supports a stretch timeout and an
// FSM-controlled force-low. Also emits rise/fall edge strobes and mid-phase
// SDA sample/shift strobes. Every output is registered.
module i2c_scl_gen #(
  parameter int CNT_W = 16,
  parameter int TMO_W = 20
) (
  input  logic             i2c_core_clk_i,
  input  logic             i2c_core_rst_ni,
  input  logic             scl_en_i,
  input  logic             scl_low_i,
  input  logic [CNT_W-1:0] half_period_i,
  input  logic             stretch_en_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             scl_i,
  output logic             i2c_scl_o,
  output logic             scl_rise_o,
  output logic             scl_fall_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic             stretch_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STRETCH,
    ST_FORCE_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] h_new;
  logic             cnt_term;
  logic             tmo_term;
  logic             tmo_hit;
  logic             scl_d;

  // Next-state, counter and half-period sampling; scl_low_i outranks everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    tmo_d    = tmo_q;
    tmo_hit  = 1'b0;
    h_new    = (half_period_i == '0) ? CNT_W'(1) : half_period_i;
    cnt_term = (cnt_q == hp_q - CNT_W'(1));
    tmo_term = (timeout_i != '0) && (tmo_q == timeout_i - TMO_W'(1));
    if (scl_low_i) begin
      state_d = ST_FORCE_LOW;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          tmo_d = '0;
          if (scl_en_i) begin
            state_d = ST_HIGH;
            hp_d    = h_new;
          end
        end
        ST_HIGH: begin
          if (!scl_en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
          end else if (cnt_q == '0 && stretch_en_i && !scl_i) begin
            // Target is holding SCL low right after we released it.
            state_d = ST_STRETCH;
            tmo_d   = '0;
          end else if (cnt_term) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            hp_d    = h_new;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (!scl_en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
          end else if (cnt_term) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            hp_d    = h_new;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STRETCH: begin
          if (!scl_en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
          end else if (scl_i) begin
            // Release seen: a full high phase follows.
            state_d = ST_HIGH;
            cnt_d   = '0;
            tmo_d   = '0;
            hp_d    = h_new;
          end else if (tmo_term) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            tmo_hit = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_FORCE_LOW: begin
          cnt_d = '0;
          tmo_d = '0;
          if (scl_en_i) begin
            state_d = ST_LOW;
            hp_d    = h_new;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
    scl_d = (state_d == ST_IDLE) || (state_d == ST_HIGH) || (state_d == ST_STRETCH);
  end

  // State registers plus outputs registered from the next-state values.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!i2c_core_rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hp_q       <= CNT_W'(1);
      tmo_q      <= '0;
      i2c_scl_o  <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      sample_o   <= 1'b0;
      shift_o    <= 1'b0;
      stretch_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      tmo_q      <= tmo_d;
      i2c_scl_o  <= scl_d;
      scl_rise_o <= scl_d & ~i2c_scl_o;
      scl_fall_o <= ~scl_d & i2c_scl_o;
      sample_o   <= (state_d == ST_HIGH) && (cnt_d == (hp_d >> 1));
      shift_o    <= (state_d == ST_LOW) && (cnt_d == (hp_d >> 1));
      stretch_o  <= (state_d == ST_STRETCH);
      timeout_o  <= tmo_hit;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Testbench for i2c_scl_gen: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a phase-level behavioural model.
module tb_i2c_scl_gen;
  localparam int CNT_W = 16;
  localparam int TMO_W = 20;

  // Output vector bit positions
  localparam int B_SCL = 6, B_RISE = 5, B_FALL = 4, B_SAMPLE = 3;
  localparam int B_SHIFT = 2, B_STRETCH = 1, B_TMO = 0;

  // Model phase kinds
  localparam int M_IDLE = 0, M_HIGH = 1, M_LOW = 2, M_STR = 3, M_FL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             scl_en;
  logic             scl_low;
  logic [CNT_W-1:0] half_period;
  logic             stretch_en;
  logic [TMO_W-1:0] timeout;
  logic             scl_in;
  logic             scl_out, scl_rise, scl_fall, sample, shift, stretch, tmo_pulse;

  i2c_scl_gen #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .i2c_core_clk_i (clk),
    .i2c_core_rst_ni(rst_n),
    .scl_en_i       (scl_en),
    .scl_low_i      (scl_low),
    .half_period_i  (half_period),
    .stretch_en_i   (stretch_en),
    .timeout_i      (timeout),
    .scl_i          (scl_in),
    .i2c_scl_o      (scl_out),
    .scl_rise_o     (scl_rise),
    .scl_fall_o     (scl_fall),
    .sample_o       (sample),
    .shift_o        (shift),
    .stretch_o      (stretch),
    .timeout_o      (tmo_pulse)
  );

  logic [6:0] dut_vec;
  assign dut_vec = {scl_out, scl_rise, scl_fall, sample, shift, stretch, tmo_pulse};

  int checks   = 0;
  int failures = 0;

  // Bus model: scl_i follows our drive unless a target holds it low.
  bit follow = 1'b0;
  bit forced = 1'b1;
  int hold   = 0;

  // ---------------- behavioural model ----------------
  // Tracks the phase kind, its length and cycles left, producing the
  // expected output vector for the cycle following each clock edge.
  logic [6:0] exp_q[$];
  int m_mode = M_IDLE;
  int m_len  = 1;
  int m_left = 0;
  int m_tmo  = 0;
  bit m_scl  = 1'b1;

  initial begin : model
    int h, pos;
    bit prev, hit;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = M_IDLE; m_len = 1; m_left = 0; m_tmo = 0; m_scl = 1'b1;
        exp_q.push_back(7'b1000000);
      end else begin
        h    = (half_period == 0) ? 1 : int'(half_period);
        hit  = 1'b0;
        prev = m_scl;
        if (scl_low) begin
          m_mode = M_FL; m_tmo = 0;
        end else if (m_mode == M_IDLE) begin
          if (scl_en) begin m_mode = M_HIGH; m_len = h; m_left = h; end
        end else if (m_mode == M_FL) begin
          if (scl_en) begin m_mode = M_LOW; m_len = h; m_left = h; end
          else m_mode = M_IDLE;
        end else if (!scl_en) begin
          m_mode = M_IDLE; m_tmo = 0;
        end else if (m_mode == M_HIGH) begin
          if (m_left == m_len && stretch_en && !scl_in) begin m_mode = M_STR; m_tmo = 0; end
          else if (m_left == 1) begin m_mode = M_LOW; m_len = h; m_left = h; end
          else m_left--;
        end else if (m_mode == M_LOW) begin
          if (m_left == 1) begin m_mode = M_HIGH; m_len = h; m_left = h; end
          else m_left--;
        end else begin
          if (scl_in) begin m_mode = M_HIGH; m_len = h; m_left = h; m_tmo = 0; end
          else if (timeout != 0 && m_tmo + 1 == int'(timeout)) begin
            m_mode = M_IDLE; m_tmo = 0; hit = 1'b1;
          end else m_tmo++;
        end
        m_scl = (m_mode != M_LOW) && (m_mode != M_FL);
        pos   = m_len - m_left;
        exp_q.push_back({m_scl, m_scl & ~prev, ~m_scl & prev,
                         (m_mode == M_HIGH) && (pos == m_len / 2),
                         (m_mode == M_LOW) && (pos == m_len / 2),
                         m_mode == M_STR, hit});
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin : compare
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_vec !== e) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t got=%b exp=%b (scl,rise,fall,sample,shift,stretch,tmo)",
                   $time, dut_vec, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    scl_in = follow ? (scl_out & (hold == 0)) : forced;
    if (hold > 0) hold--;
    @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Tick until output bit idx is set; n = ticks taken, -1 on expired budget.
  task automatic wait_sig(input int idx, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (dut_vec[idx]) begin n = i; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n, cnt_a, cnt_b, cnt_c;
    rst_n = 1'b0; scl_en = 1'b0; scl_low = 1'b0; half_period = '0;
    stretch_en = 1'b0; timeout = '0; scl_in = 1'b1;

    // Reset state
    repeat (3) tick();
    check_int("reset_vec", int'(dut_vec), 7'b1000000);
    rst_n = 1'b1; follow = 1'b1;
    tick();
    check_int("idle_vec", int'(dut_vec), 7'b1000000);

    // Half period 4: 8-cycle period, sample/shift at counter 2
    half_period = 4; scl_en = 1'b1;
    wait_sig(B_FALL, 20, n);   check_int("hp4_first_fall", n > 0, 1);
    wait_sig(B_RISE, 20, n);   check_int("hp4_low_len", n, 4);
    wait_sig(B_SAMPLE, 20, n); check_int("hp4_sample_pos", n, 2);
    wait_sig(B_FALL, 20, n);   check_int("hp4_sample_to_fall", n, 2);
    wait_sig(B_SHIFT, 20, n);  check_int("hp4_shift_pos", n, 2);
    wait_sig(B_FALL, 20, n);   check_int("hp4_shift_to_fall", n, 6);

    // Half period 0 behaves as 1: 2-cycle period
    half_period = 0;
    wait_sig(B_FALL, 20, n);
    wait_sig(B_FALL, 20, n);
    wait_sig(B_RISE, 20, n);   check_int("hp0_low_len", n, 1);
    wait_sig(B_FALL, 20, n);   check_int("hp0_high_len", n, 1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt_a += int'(sample);
      cnt_b += int'(shift);
    end
    check_int("hp0_samples", cnt_a, 5);
    check_int("hp0_shifts", cnt_b, 5);

    // Stretch for 10 cycles, no timeout
    half_period = 4; stretch_en = 1'b1; timeout = 0;
    wait_sig(B_RISE, 30, n);   check_int("str_rise_seen", n > 0, 1);
    hold = 10;
    wait_sig(B_STRETCH, 5, n); check_int("str_entry", n, 1);
    cnt_a = 0; cnt_c = 0;
    for (int i = 0; i < 40 && stretch; i++) begin
      cnt_a++; cnt_c += int'(tmo_pulse); tick();
    end
    check_int("str_len", cnt_a, 10);
    cnt_b = 0;
    for (int i = 0; i < 40 && scl_out && !stretch; i++) begin
      cnt_b++; cnt_c += int'(tmo_pulse); tick();
    end
    check_int("str_high_after", cnt_b, 4);
    check_int("str_no_timeout", cnt_c, 0);

    // Stuck-low bus with timeout 5
    timeout = 5; follow = 1'b0; forced = 1'b0;
    wait_sig(B_STRETCH, 20, n); check_int("tmo_stretch_seen", n > 0, 1);
    cnt_a = 0;
    for (int i = 0; i < 40 && stretch; i++) begin cnt_a++; tick(); end
    check_int("tmo_stretch_len", cnt_a, 5);
    check_int("tmo_pulse", int'(tmo_pulse), 1);
    check_int("tmo_scl_high", int'(scl_out), 1);
    scl_en = 1'b0; follow = 1'b1; stretch_en = 1'b0; timeout = 0;
    tick();
    check_int("tmo_pulse_once", int'(tmo_pulse), 0);
    scl_en = 1'b1;

    // Force low for 3 cycles mid-high
    wait_sig(B_SAMPLE, 30, n); check_int("fl_sample_seen", n > 0, 1);
    scl_low = 1'b1;
    tick();
    check_int("fl_fall", int'(scl_fall), 1);
    tick(); tick();
    scl_low = 1'b0;
    cnt_a = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (scl_out) break;
      cnt_a++;
    end
    check_int("fl_low_len", cnt_a, 7);
    check_int("fl_rise", int'(scl_rise), 1);

    // Reset during LOW
    wait_sig(B_SHIFT, 30, n); check_int("rst_shift_seen", n > 0, 1);
    rst_n = 1'b0;
    tick();
    check_int("rst_in_low_vec", int'(dut_vec), 7'b1000000);
    rst_n = 1'b1;

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      scl_en  = ($urandom_range(0, 19) != 0);
      scl_low = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) half_period = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) stretch_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) timeout = TMO_W'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) follow = ~follow;
      forced = 1'($urandom_range(0, 1));
      if (hold == 0 && $urandom_range(0, 29) == 0) hold = $urandom_range(1, 8);
      tick();
    end
    rst_n = 1'b1; scl_en = 1'b0; scl_low = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
- REQ-001: Parameter CNT_W, default 16: width of half-period counter and half_period_i.
- REQ-002: Parameter TMO_W, default 20: width of stretch-timeout counter and timeout_i.
- REQ-003: i2c_core_clk_i  input  1  i2c core clock; all logic on its rising edge.
- REQ-004: i2c_core_rst_ni  input  1  reset, synchronous, active-low.
- REQ-005: scl_en_i  input  1  enable SCL toggling.
- REQ-006: scl_low_i  input  1  FSM force-low request; highest priority after reset.
- REQ-007: half_period_i  input  CNT_W  SCL half-period in core cycles; 0 treated as 1.
- REQ-008: stretch_en_i  input  1  enable clock-stretch detection.
- REQ-009: timeout_i  input  TMO_W  stretch timeout in core cycles; 0 disables timeout.
- REQ-010: scl_i  input  1  sampled bus SCL level, already synchronised.
- REQ-011: i2c_scl_o  output  1  SCL drive (1 = release/high, 0 = drive low).
- REQ-012: scl_rise_o / scl_fall_o  output  1 each  one-cycle strobes.
- REQ-013: sample_o  output  1  one-cycle mid-high strobe (SDA sample point).
- REQ-014: shift_o  output  1  one-cycle mid-low strobe (SDA change point).
- REQ-015: stretch_o  output  1  high while in STRETCH.
- REQ-016: timeout_o  output  1  one-cycle pulse on stretch timeout.

Function
- REQ-017: All outputs registered; states IDLE, HIGH, LOW, STRETCH, FORCE_LOW.
- REQ-018: H = max(half_period_i,1); sampled into hp_q on every entry to HIGH or LOW; mid-phase changes of half_period_i have no effect until next phase.
- REQ-019: Phase counter counts 0..hp_q-1; terminal count is counter == hp_q-1; no wrap beyond terminal.
- REQ-020: IDLE: i2c_scl_o=1, counters 0; scl_en_i=1 -> HIGH (counter 0) next cycle.
- REQ-021: HIGH: i2c_scl_o=1; at terminal count -> LOW.
- REQ-022: HIGH with counter==0, stretch_en_i=1, scl_i=0 -> STRETCH; counter held at 0.
- REQ-023: LOW: i2c_scl_o=0; at terminal count -> HIGH.
- REQ-024: STRETCH: i2c_scl_o=1, stretch_o=1, timeout counter increments each cycle; scl_i=1 -> HIGH with counter 0 (full high phase follows), timeout counter cleared.
- REQ-025: STRETCH with timeout_i!=0 and timeout counter == timeout_i-1 -> IDLE, timeout_o=1 for one cycle.
- REQ-026: scl_en_i=0 in HIGH/LOW/STRETCH -> IDLE next cycle; scl_low_i takes priority over this.
- REQ-027: scl_low_i=1 in any state -> FORCE_LOW next cycle; counters cleared; i2c_scl_o=0.
- REQ-028: FORCE_LOW with scl_low_i=0: scl_en_i=1 -> LOW (counter 0, full low phase); else -> IDLE.
- REQ-029: scl_fall_o=1 exactly in the first cycle i2c_scl_o is 0 after being 1; scl_rise_o=1 exactly in the first cycle it is 1 after being 0.
- REQ-030: sample_o=1 in HIGH when counter == hp_q/2 (floor); shift_o=1 in LOW when counter == hp_q/2; with hp_q=1 each fires once per phase.
- REQ-031: sample_o never asserted in STRETCH; asserted after stretch release per REQ-030.
- REQ-032: SCL period = 2*hp_q cycles when unstretched; duty 50%.

Reset
- REQ-033: While i2c_core_rst_ni=0 at a clock edge: state IDLE, counters 0, hp_q=1, i2c_scl_o=1, all strobes, stretch_o, timeout_o = 0.
- REQ-034: Reset asserted mid-operation (any state) overrides all inputs; first cycle after release is IDLE.

Verification
- REQ-035: half_period_i=4, scl_en_i=1, scl_i follows i2c_scl_o -> period 8 cycles, 4 high/4 low; sample_o at high counter 2, shift_o at low counter 2.
- REQ-036: half_period_i=0 -> period 2 cycles; rise/fall strobes alternate every cycle; sample_o/shift_o once per phase.
- REQ-037: stretch_en_i=1, hold scl_i=0 for 10 cycles after HIGH entry, timeout_i=0 -> stretch_o high 10 cycles, then full 4-cycle high phase; no timeout_o.
- REQ-038: stretch_en_i=1, scl_i stuck 0, timeout_i=5 -> timeout_o pulses once after 5 STRETCH cycles, state IDLE, i2c_scl_o=1.
- REQ-039: scl_low_i pulsed 3 cycles mid-HIGH with scl_en_i=1 -> scl_fall_o next cycle, low for 3 cycles plus full hp_q low phase, then HIGH.
- REQ-040: Reset asserted during LOW -> next cycle i2c_scl_o=1, no scl_rise_o, all strobes 0.
